// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier: controller state
// encoding and a constant-evaluable ceiling log2.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element: multiply-accumulate on the a/b operands flowing
// through it, forwarding a east and b south with one cycle of delay.
module mac_pe #(
    parameter int W     = 16,
    parameter int ACC_W = 34
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [W-1:0]     o_a,
    output logic [W-1:0]     o_b,
    output logic [ACC_W-1:0] o_acc
);

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [ACC_W-1:0] w_prod;

    // Extending both operands to ACC_W first makes the low ACC_W bits of the
    // plain product equal the correctly signed/unsigned product mod 2^ACC_W.
    assign w_a_ext = {{(ACC_W-W){i_mode & i_a[W-1]}}, i_a};
    assign w_b_ext = {{(ACC_W-W){i_mode & i_b[W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= r_acc + w_prod;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic array computing C = A x B, with the
// operand skew/feed sequencing and the valid/ready handshakes.
module systolic_matmul
    import systolic_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int ACC_W = 2*W + clog2(N)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_mode,
    input  logic [W*N*N-1:0]     i_A,
    input  logic [W*N*N-1:0]     i_B,
    output logic [ACC_W*N*N-1:0] o_C,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy
);

    // Handshakes: operands transfer on an edge with i_valid & o_ready; a
    // result transfers on an edge with o_valid & i_ready. Both may coincide.
    localparam int KW = clog2(3*N) + 1;
    // Edge operands pass through a skew register before reaching the array,
    // so feeding runs one step beyond the last useful index to land the
    // final product exactly before DRAIN.
    localparam logic [KW-1:0] FEED_LAST = KW'(3*N - 2);

    state_t               r_state;
    logic [KW-1:0]        r_k;
    logic                 r_live;
    logic                 r_mode;
    logic                 r_valid;
    logic                 r_busy;
    logic [W*N*N-1:0]     r_a;
    logic [W*N*N-1:0]     r_b;
    logic [W-1:0]         r_west  [N];
    logic [W-1:0]         r_north [N];
    logic [ACC_W*N*N-1:0] r_c;

    logic                 w_accept;
    logic [W-1:0]         w_west_nxt  [N];
    logic [W-1:0]         w_north_nxt [N];
    logic [W-1:0]         w_h [N][N+1];
    logic [W-1:0]         w_v [N+1][N];
    logic [ACC_W*N*N-1:0] w_acc;

    assign o_ready  = r_live & ((r_state == S_IDLE) | ((r_state == S_DONE) & i_ready));
    assign w_accept = i_valid & o_ready;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;
    assign o_C      = r_c;

    // Row i is fed A[i][k-i], column j is fed B[k-j][j]; zero off the edges.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_west_nxt[i]  = '0;
            w_north_nxt[i] = '0;
            for (int m = 0; m < N; m++) begin
                if (int'(r_k) == i + m) begin
                    w_west_nxt[i]  = r_a[(i*N+m)*W +: W];
                    w_north_nxt[i] = r_b[(m*N+i)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_live  <= 1'b0;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            for (int i = 0; i < N; i++) begin
                r_west[i]  <= '0;
                r_north[i] <= '0;
            end
        end else begin
            r_live <= 1'b1;
            for (int i = 0; i < N; i++) begin
                r_west[i]  <= (r_state == S_FEED) ? w_west_nxt[i]  : '0;
                r_north[i] <= (r_state == S_FEED) ? w_north_nxt[i] : '0;
            end
            if (w_accept) begin
                r_a    <= i_A;
                r_b    <= i_B;
                r_mode <= i_mode;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_FEED;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (r_k == FEED_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_k     <= '0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_c     <= w_acc;
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        if (w_accept) begin
                            r_state <= S_FEED;
                            r_k     <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign w_h[gi][0] = r_west[gi];
        assign w_v[0][gi] = r_north[gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_pe #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_pe (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_clr   (w_accept),
                .i_en    (r_busy),
                .i_mode  (r_mode),
                .i_a     (w_h[gi][gj]),
                .i_b     (w_v[gi][gj]),
                .o_a     (w_h[gi][gj+1]),
                .o_b     (w_v[gi+1][gj]),
                .o_acc   (w_acc[(gi*N+gj)*ACC_W +: ACC_W])
            );
        end
    end

endmodule

// File: tb/tb_systolic_matmul.sv
// Randomised scoreboard bench for systolic_matmul: a W=16/N=3 instance and a
// W=8/N=4 instance, checked against a plain-arithmetic matrix product.
module tb_systolic_matmul;

  localparam int W3 = 16, N3 = 3, AW3 = 34;
  localparam int W4 = 8,  N4 = 4, AW4 = 18;

  typedef logic [319:0] res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                v3 = 1'b0, mode3 = 1'b0, ir3 = 1'b0;
  logic                rdy3, ov3, busy3;
  logic [W3*N3*N3-1:0] a3 = '0, b3 = '0;
  logic [AW3*N3*N3-1:0] c3;

  logic                v4 = 1'b0, mode4 = 1'b0, ir4 = 1'b0;
  logic                rdy4, ov4, busy4;
  logic [W4*N4*N4-1:0] a4 = '0, b4 = '0;
  logic [AW4*N4*N4-1:0] c4;

  systolic_matmul #(.W(W3), .N(N3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .o_ready(rdy3), .i_mode(mode3),
    .i_A(a3), .i_B(b3), .o_C(c3), .o_valid(ov3), .i_ready(ir3), .o_busy(busy3));

  systolic_matmul #(.W(W4), .N(N4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(rdy4), .i_mode(mode4),
    .i_A(a4), .i_B(b4), .o_C(c4), .o_valid(ov4), .i_ready(ir4), .o_busy(busy4));

  int n_cmp = 0, n_bad = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_t exp3_q[$], exp4_q[$];
  longint lat3_q[$], lat4_q[$];
  bit ir3_rand = 1'b0, ir4_rand = 1'b0;
  logic ir3_force = 1'b1, ir4_force = 1'b1;

  always @(posedge clk) begin
    #1;
    ir3 = ir3_rand ? 1'($urandom_range(0, 1)) : ir3_force;
    ir4 = ir4_rand ? 1'($urandom_range(0, 1)) : ir4_force;
  end

  task automatic check(input string name, input res_t act, input res_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  function automatic longint elem(input logic [1023:0] v, input int idx, input int w, input logic m);
    longint x;
    x = 0;
    for (int b = 0; b < w; b++) x[b] = v[idx*w + b];
    if (m && x[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  function automatic res_t ref_mm(input int n, input int w, input int accw,
                                  input logic [1023:0] a, input logic [1023:0] b, input logic m);
    res_t r;
    longint s;
    r = '0;
    for (int rr = 0; rr < n; rr++)
      for (int cc = 0; cc < n; cc++) begin
        s = 0;
        for (int kk = 0; kk < n; kk++)
          s = s + elem(a, rr*n + kk, w, m) * elem(b, kk*n + cc, w, m);
        for (int bt = 0; bt < accw; bt++) r[(rr*n + cc)*accw + bt] = s[bt];
      end
    return r;
  endfunction

  function automatic res_t fill_res(input int cnt, input int accw, input longint val);
    res_t r;
    r = '0;
    for (int e = 0; e < cnt; e++)
      for (int bt = 0; bt < accw; bt++) r[e*accw + bt] = val[bt];
    return r;
  endfunction

  function automatic logic [1023:0] rnd_vec();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- monitors ----------------
  logic prev_ov3 = 1'b0, hold3 = 1'b0;
  res_t hold_c3;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov3 = 1'b0;
      hold3 = 1'b0;
    end else begin
      if (ov3 && !prev_ov3) begin
        if (lat3_q.size() == 0) flag("dut3 unexpected o_valid");
        else check("dut3 latency", res_t'(cyc - lat3_q.pop_front()), res_t'(3*N3));
      end
      if (hold3) check("dut3 held o_C stable", res_t'(c3), hold_c3);
      if (ov3 && !ir3) begin
        check("dut3 o_ready while held", res_t'(rdy3), res_t'(0));
        hold3 = 1'b1;
        hold_c3 = res_t'(c3);
      end else begin
        hold3 = 1'b0;
      end
      if (ov3 && ir3) begin
        if (exp3_q.size() == 0) flag("dut3 result with empty scoreboard");
        else check("dut3 o_C", res_t'(c3), exp3_q.pop_front());
      end
      prev_ov3 = ov3;
    end
  end

  logic prev_ov4 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov4 = 1'b0;
    end else begin
      if (ov4 && !prev_ov4) begin
        if (lat4_q.size() == 0) flag("dut4 unexpected o_valid");
        else check("dut4 latency", res_t'(cyc - lat4_q.pop_front()), res_t'(3*N4));
      end
      if (ov4 && ir4) begin
        if (exp4_q.size() == 0) flag("dut4 result with empty scoreboard");
        else check("dut4 o_C", res_t'(c4), exp4_q.pop_front());
      end
      prev_ov4 = ov4;
    end
  end

  // ---------------- drivers ----------------
  task automatic send3(input logic [W3*N3*N3-1:0] a, input logic [W3*N3*N3-1:0] b,
                       input logic m, input res_t e);
    int t;
    @(posedge clk); #1;
    a3 = a; b3 = b; mode3 = m; v3 = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (rdy3) begin
        exp3_q.push_back(e);
        lat3_q.push_back(cyc + 1);
        break;
      end
      t++;
      if (t > 300) begin flag("dut3 acceptance timeout"); break; end
    end
    @(posedge clk); #1;
    v3 = 1'b0; a3 = ~a3; b3 = ~b3; mode3 = ~mode3;
  endtask

  task automatic send4(input logic [W4*N4*N4-1:0] a, input logic [W4*N4*N4-1:0] b,
                       input logic m, input res_t e);
    int t;
    @(posedge clk); #1;
    a4 = a; b4 = b; mode4 = m; v4 = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (rdy4) begin
        exp4_q.push_back(e);
        lat4_q.push_back(cyc + 1);
        break;
      end
      t++;
      if (t > 300) begin flag("dut4 acceptance timeout"); break; end
    end
    @(posedge clk); #1;
    v4 = 1'b0; a4 = ~a4; b4 = ~b4;
  endtask

  task automatic drain(input int which);
    int t;
    t = 0;
    while ((which == 3) ? (exp3_q.size() != 0) : (exp4_q.size() != 0)) begin
      @(negedge clk);
      t++;
      if (t > 500) begin flag("drain timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W3*N3*N3-1:0] opa, opb;
  logic [W4*N4*N4-1:0] opa4, opb4;
  logic [1023:0] tmp_a, tmp_b;
  res_t e3;
  logic [33:0] neg6;

  initial begin
    repeat (2) @(negedge clk);
    check("reset dut3 o_valid", res_t'(ov3), res_t'(0));
    check("reset dut3 o_busy", res_t'(busy3), res_t'(0));
    check("reset dut3 o_ready", res_t'(rdy3), res_t'(0));
    check("reset dut3 o_C", res_t'(c3), res_t'(0));
    check("reset dut4 o_ready", res_t'(rdy4), res_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("dut3 o_ready before first edge", res_t'(rdy3), res_t'(0));
    @(negedge clk);
    check("dut3 o_ready after first edge", res_t'(rdy3), res_t'(1));

    // all ones x all ones, unsigned: every element 3
    for (int i = 0; i < 9; i++) begin opa[i*16 +: 16] = 16'h0001; opb[i*16 +: 16] = 16'h0001; end
    send3(opa, opb, 1'b0, fill_res(9, AW3, 3));
    drain(3);

    // identity x (1..9) gives B back
    opa = '0; e3 = '0;
    for (int i = 0; i < 9; i++) begin opb[i*16 +: 16] = 16'(i + 1); e3[i*AW3 +: AW3] = 34'(i + 1); end
    for (int i = 0; i < 3; i++) opa[(i*3 + i)*16 +: 16] = 16'h0001;
    send3(opa, opb, 1'b0, e3);
    drain(3);

    // 0xFFFF x 2: -6 signed, 393210 unsigned
    for (int i = 0; i < 9; i++) begin opa[i*16 +: 16] = 16'hFFFF; opb[i*16 +: 16] = 16'h0002; end
    neg6 = 34'd0 - 34'd6;
    send3(opa, opb, 1'b1, fill_res(9, AW3, longint'(neg6)));
    drain(3);
    send3(opa, opb, 1'b0, fill_res(9, AW3, 393210));
    drain(3);

    // consumer stalls 5 cycles, then takes result while a new pair is offered
    ir3_force = 1'b0;
    tmp_a = rnd_vec(); tmp_b = rnd_vec();
    opa = tmp_a[143:0]; opb = tmp_b[143:0];
    send3(opa, opb, 1'b1, ref_mm(N3, W3, AW3, 1024'(opa), 1024'(opb), 1'b1));
    begin
      int t;
      t = 0;
      while (!ov3 && t < 100) begin @(negedge clk); t++; end
      if (!ov3) flag("dut3 o_valid never rose before stall");
    end
    repeat (3) @(posedge clk);
    tmp_a = rnd_vec(); tmp_b = rnd_vec();
    opa = tmp_a[143:0]; opb = tmp_b[143:0];
    fork
      send3(opa, opb, 1'b0, ref_mm(N3, W3, AW3, 1024'(opa), 1024'(opb), 1'b0));
      begin repeat (2) @(posedge clk); ir3_force = 1'b1; end
    join
    @(negedge clk);
    check("dut3 busy after overlapped accept", res_t'(busy3), res_t'(1));
    check("dut3 o_valid dropped after take", res_t'(ov3), res_t'(0));
    drain(3);

    // reset in the middle of FEED aborts the computation
    tmp_a = rnd_vec(); tmp_b = rnd_vec();
    opa = tmp_a[143:0]; opb = tmp_b[143:0];
    send3(opa, opb, 1'b1, ref_mm(N3, W3, AW3, 1024'(opa), 1024'(opb), 1'b1));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    exp3_q.delete(); lat3_q.delete();
    @(negedge clk);
    check("mid-reset dut3 o_busy", res_t'(busy3), res_t'(0));
    check("mid-reset dut3 o_valid", res_t'(ov3), res_t'(0));
    check("mid-reset dut3 o_C", res_t'(c3), res_t'(0));
    check("mid-reset dut3 o_ready", res_t'(rdy3), res_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("dut3 o_ready after reset release", res_t'(rdy3), res_t'(1));
    repeat (30) @(negedge clk);
    tmp_a = rnd_vec(); tmp_b = rnd_vec();
    opa = tmp_a[143:0]; opb = tmp_b[143:0];
    send3(opa, opb, 1'b1, ref_mm(N3, W3, AW3, 1024'(opa), 1024'(opb), 1'b1));
    drain(3);

    // random W=16 runs, random mode, random consumer readiness
    ir3_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      logic m;
      tmp_a = rnd_vec(); tmp_b = rnd_vec();
      opa = tmp_a[143:0]; opb = tmp_b[143:0];
      m = 1'($urandom_range(0, 1));
      send3(opa, opb, m, ref_mm(N3, W3, AW3, 1024'(opa), 1024'(opb), m));
    end
    drain(3);

    // N=4, W=8 random signed runs
    ir4_rand = 1'b1;
    for (int r = 0; r < 100; r++) begin
      tmp_a = rnd_vec(); tmp_b = rnd_vec();
      opa4 = tmp_a[127:0]; opb4 = tmp_b[127:0];
      send4(opa4, opb4, 1'b1, ref_mm(N4, W4, AW4, 1024'(opa4), 1024'(opb4), 1'b1));
    end
    drain(4);
    repeat (5) @(negedge clk);
    if (lat3_q.size() != 0 || lat4_q.size() != 0) flag("results still outstanding at end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
